line_clear: RTL and testbench



---
 rtl/tetris_pkg.sv | 23 ++
 rtl/lc_row_full.sv | 14 +
 rtl/line_clear.sv | 131 +++++++++++++
 tb/tb_line_clear.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris datapath types: board geometry, line-clear FSM states,
// and a row-slice helper for the flat r*COLS+c board layout.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_BITS = BOARD_ROWS * BOARD_COLS;

  typedef enum logic [1:0] {
    LC_IDLE   = 2'd0,
    LC_SCAN   = 2'd1,
    LC_FILL   = 2'd2,
    LC_FINISH = 2'd3
  } lc_state_t;

  function automatic logic [BOARD_COLS-1:0] row_slice(
    input logic [0:BOARD_BITS-1] b,
    input int unsigned           r
  );
    return b[r*BOARD_COLS +: BOARD_COLS];
  endfunction

endpackage

// File: rtl/lc_row_full.sv
// Full-row detector: row (COLS bits) in, full=1 when every cell is set.
// Ports: row, full.
module lc_row_full
  import tetris_pkg::*;
#(
  parameter int COLS = BOARD_COLS
) (
  input  logic [COLS-1:0] row,
  output logic            full
);

  assign full = &row;

endmodule

// File: rtl/line_clear.sv
// Row-elimination stage: snapshots a board on start, removes full rows
// by in-place compaction, zero-fills the top, publishes board and counts.
// Ports: clk, clrn, start, board_in -> busy, done, board_out, lines,
// total_lines (saturating running total).
module line_clear
  import tetris_pkg::*;
#(
  parameter int ROWS  = BOARD_ROWS,
  parameter int COLS  = BOARD_COLS,
  parameter int TOT_W = 16
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 start,
  input  logic [0:ROWS*COLS-1] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [0:ROWS*COLS-1] board_out,
  output logic [2:0]           lines,
  output logic [TOT_W-1:0]     total_lines
);

  localparam int BW = ROWS * COLS;
  localparam int IW = $clog2(BW);
  localparam logic [4:0] LAST = 5'(ROWS - 1);

  lc_state_t state, state_nx;

  logic [4:0]      rd;
  logic [4:0]      wr;
  logic [4:0]      n;
  logic [0:BW-1]   work;
  logic [IW-1:0]   rd_base;
  logic [IW-1:0]   wr_base;
  logic [COLS-1:0] rd_row;
  logic            rd_full;
  logic [4:0]      n_scan;
  logic [2:0]      n_sat;
  logic [TOT_W:0]  tot_sum;

  assign rd_base = IW'(int'(rd) * COLS);
  assign wr_base = IW'(int'(wr) * COLS);
  assign rd_row  = work[rd_base +: COLS];

  lc_row_full #(
    .COLS(COLS)
  ) u_full (
    .row (rd_row),
    .full(rd_full)
  );

  // n including the row under the read pointer this edge
  assign n_scan = n + 5'(rd_full);

  // more than 4 rows cannot occur in legal play; report at most 4
  assign n_sat   = (n > 5'd4) ? 3'd4 : n[2:0];
  assign tot_sum = {1'b0, total_lines} + (TOT_W+1)'(n_sat);

  assign busy = (state != LC_IDLE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= LC_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LC_IDLE: begin
        if (start) state_nx = LC_SCAN;
      end
      LC_SCAN: begin
        if (rd == LAST)
          state_nx = (n_scan != 5'd0) ? LC_FILL : LC_FINISH;
      end
      LC_FILL: begin
        if (wr == LAST) state_nx = LC_FINISH;
      end
      LC_FINISH: state_nx = LC_IDLE;
      default:   state_nx = LC_IDLE;
    endcase
  end

  // wr never passes rd, so the kept row is copied down in place
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd          <= '0;
      wr          <= '0;
      n           <= '0;
      work        <= '0;
      board_out   <= '0;
      lines       <= '0;
      total_lines <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        LC_IDLE: begin
          if (start) begin
            work <= board_in;
            rd   <= '0;
            wr   <= '0;
            n    <= '0;
          end
        end
        LC_SCAN: begin
          rd <= rd + 5'd1;
          if (rd_full) begin
            n <= n_scan;
          end else begin
            work[wr_base +: COLS] <= rd_row;
            wr <= wr + 5'd1;
          end
        end
        LC_FILL: begin
          work[wr_base +: COLS] <= '0;
          wr <= wr + 5'd1;
        end
        LC_FINISH: begin
          board_out   <= work;
          lines       <= n_sat;
          total_lines <= tot_sum[TOT_W] ? {TOT_W{1'b1}}
                                        : tot_sum[TOT_W-1:0];
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear.sv
// Randomized scoreboard bench for line_clear: stimulus pushes model results,
// a negedge monitor pops and compares on every done pulse.
module tb_line_clear;
  import tetris_pkg::*;

  localparam int R = BOARD_ROWS;
  localparam int C = BOARD_COLS;
  localparam int B = BOARD_BITS;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         start = 1'b0;
  logic [0:B-1] board_in = '0;
  logic         busy, done;
  logic [0:B-1] board_out;
  logic [2:0]   lines;
  logic [15:0]  total_lines;

  logic         start2 = 1'b0;
  logic [0:B-1] board2 = '0;
  logic         busy2, done2;
  logic [0:B-1] bout2;
  logic [2:0]   lines2;
  logic [2:0]   total2;

  always #5 clk = ~clk;

  line_clear dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .board_in   (board_in),
    .busy       (busy),
    .done       (done),
    .board_out  (board_out),
    .lines      (lines),
    .total_lines(total_lines)
  );

  line_clear #(.TOT_W(3)) dut3 (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start2),
    .board_in   (board2),
    .busy       (busy2),
    .done       (done2),
    .board_out  (bout2),
    .lines      (lines2),
    .total_lines(total2)
  );

  typedef struct {
    logic [0:B-1] board;
    logic [2:0]   lines;
    logic [15:0]  total;
    longint       due;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     model_total = 0;

  logic [0:B-1] pub_board = '0;
  logic [2:0]   pub_lines = '0;
  logic [15:0]  pub_total = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: keep non-full rows in order from the bottom, zero the rest
  function automatic void ref_clear(input logic [0:B-1] b,
                                    output logic [0:B-1] o,
                                    output int n);
    int  k;
    bit  full;
    o = '0;
    n = 0;
    k = 0;
    for (int r = 0; r < R; r++) begin
      full = 1'b1;
      for (int c = 0; c < C; c++)
        if (b[r*C+c] !== 1'b1) full = 1'b0;
      if (full) n++;
      else begin
        for (int c = 0; c < C; c++) o[k*C+c] = b[r*C+c];
        k++;
      end
    end
  endfunction

  function automatic logic [0:B-1] junk();
    logic [0:B-1] j;
    for (int i = 0; i < B; i++) j[i] = 1'($urandom_range(0, 1));
    return j;
  endfunction

  function automatic logic [0:B-1] set_row(input logic [0:B-1] b,
                                           input int r,
                                           input logic [C-1:0] p);
    for (int c = 0; c < C; c++) b[r*C+c] = p[C-1-c];
    return b;
  endfunction

  function automatic logic [0:B-1] rand_board(input int nfull);
    logic [0:B-1] b;
    bit           isf[R];
    int           placed;
    int           r;
    b = junk();
    for (int i = 0; i < R; i++) begin
      b[i*C + int'($urandom_range(0, C-1))] = 1'b0;
      isf[i] = 1'b0;
    end
    placed = 0;
    while (placed < nfull) begin
      r = int'($urandom_range(0, R-1));
      if (!isf[r]) begin
        isf[r] = 1'b1;
        b = set_row(b, r, '1);
        placed++;
      end
    end
    return b;
  endfunction

  // Called at a negedge while the model says the DUT is idle
  task automatic drive_start(input logic [0:B-1] b, output int n);
    exp_t         e;
    logic [0:B-1] o;
    int           ns;
    ref_clear(b, o, n);
    ns = (n > 4) ? 4 : n;
    model_total = (model_total + ns > 65535) ? 65535 : model_total + ns;
    e.board = o;
    e.lines = 3'(ns);
    e.total = 16'(model_total);
    e.due   = cyc + 22 + n;
    q.push_back(e);
    start    = 1'b1;
    board_in = b;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic single(input logic [0:B-1] b);
    int n;
    @(negedge clk);
    drive_start(b, n);
    @(negedge clk);
    start    = 1'b0;
    board_in = junk();
    wait_idle();
  endtask

  // start held high through the pass; second board taken in the done cycle
  task automatic b2b(input logic [0:B-1] b1, input logic [0:B-1] b2);
    int     n1, n2;
    longint due;
    @(negedge clk);
    drive_start(b1, n1);
    due = cyc + 22 + n1;
    for (int i = 0; i < 40 && cyc < due; i++) begin
      @(negedge clk);
      board_in = junk();
    end
    drive_start(b2, n2);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (clrn) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected 0");
        end else begin
          e = q.pop_front();
          chk("board_out", board_out, e.board);
          chk("lines", lines, e.lines);
          chk("total_lines", total_lines, e.total);
          chk("latency_cycle", cyc, e.due);
          pub_board = e.board;
          pub_lines = e.lines;
          pub_total = e.total;
        end
      end else begin
        chk("hold_outputs", {board_out, lines, total_lines},
            {pub_board, pub_lines, pub_total});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [0:B-1] b;
    logic [0:B-1] o;
    int           n;
    int           nf;
    int           exp3;
    int           t;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_board", board_out, 0);
    chk("rst_lines", lines, 0);
    chk("rst_total", total_lines, 0);
    clrn = 1'b1;

    single('0);

    b = '0;
    b = set_row(b, 0, '1);
    b = set_row(b, 1, 10'b1000000001);
    single(b);

    b = '0;
    for (int r = 0; r < 4; r++) b = set_row(b, r, '1);
    b = set_row(b, 4, 10'b0000011111);
    single(b);

    b = '0;
    b = set_row(b, 0, 10'b0101010101);
    b = set_row(b, 1, '1);
    b = set_row(b, 2, 10'b1100110011);
    b = set_row(b, 3, '1);
    b = set_row(b, 4, 10'b0011100001);
    single(b);

    single(rand_board(6));

    for (int i = 0; i < 30; i++) begin
      nf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7))
                                       : int'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0)
        b2b(rand_board(nf), rand_board(int'($urandom_range(0, 4))));
      else
        single(rand_board(nf));
    end

    // stray start mid-pass must be ignored
    @(negedge clk);
    drive_start(rand_board(2), n);
    @(negedge clk);
    start    = 1'b0;
    board_in = junk();
    repeat (3) @(negedge clk);
    start    = 1'b1;
    board_in = rand_board(4);
    chk("busy_mid_pass", busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset mid-pass aborts and discards
    @(negedge clk);
    drive_start(rand_board(3), n);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    clrn = 1'b0;
    q.delete();
    model_total = 0;
    pub_board   = '0;
    pub_lines   = '0;
    pub_total   = '0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_board", board_out, 0);
    chk("abort_lines", lines, 0);
    chk("abort_total", total_lines, 0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    repeat (30) @(negedge clk);
    single(rand_board(1));

    // narrow counter saturates at 7
    exp3 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start2 = 1'b1;
      board2 = rand_board(4);
      @(negedge clk);
      start2 = 1'b0;
      t = 0;
      while (!done2 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("sat_done_seen", done2, 1);
      exp3 = (exp3 + 4 > 7) ? 7 : exp3 + 4;
      ref_clear(board2, o, n);
      chk("sat_total", total2, exp3);
      chk("sat_lines", lines2, 4);
      chk("sat_board", bout2, o);
      chk("sat_busy", busy2, 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
